cache_controller: RTL and testbench
===================================

Name: cache_controller

Overview:
- Command-side initiator for the cache storage array. Accepts GET/SET/DEL requests over a valid/ready handshake and sequences the storage's write/read/delete strobes.
- Samples the storage's hit/value results and returns a status/value response over a second valid/ready handshake.
- Tracks occupancy so a SET into a full store is refused. Sits between the host command decoder and the storage array.

Parameters:
NUM_ENTRIES, 16, storage capacity in entries
KEY_WIDTH, 16, key width in bits
VALUE_WIDTH, 64, value width in bits

Ports:
clk  input  1  clock; all logic on rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  1  request present
req_ready  output  1  controller can accept a request
req_op  input  2  0=GET, 1=SET, 2=DEL, 3=invalid
req_key  input  KEY_WIDTH  request key
req_value  input  VALUE_WIDTH  SET value
resp_valid  output  1  response present
resp_ready  input  1  consumer accepts response
resp_status  output  2  0=OK, 1=NOT_FOUND, 2=FULL, 3=ERR
resp_value  output  VALUE_WIDTH  GET data (0 unless GET hit)
mem_write  output  1  storage write strobe
mem_read  output  1  storage read strobe
mem_delete  output  1  storage delete strobe
mem_key  output  KEY_WIDTH  key to storage
mem_value  output  VALUE_WIDTH  value to storage
mem_value_out  input  VALUE_WIDTH  storage lookup data (combinational from mem_key)
mem_hit  input  1  storage lookup hit (combinational from mem_key)
entry_count  output  $clog2(NUM_ENTRIES+1)  current occupied entries

Behaviour:
- Reset (async, rst_n low):
  - State IDLE; entry_count=0; all mem_* strobes=0; mem_key=0; mem_value=0.
  - resp_valid=0; resp_status=0; resp_value=0.
  - The storage shares rst_n, so the count stays consistent. Reset mid-operation abandons the request with no response.
- All mem_* outputs come directly from flops; no combinational path from req_* to mem_*. mem_delete must be glitch-free because the storage uses it as a cell reset.
- req_ready=1 only in IDLE.
- Accept: req_valid&&req_ready. Register op, req_key into mem_key and req_value into mem_value. Hold both stable until return to IDLE.
- States: IDLE, LOOKUP, DELETE, WRITE, RESPOND.
  - IDLE → LOOKUP on accept of op 0..2.
  - IDLE → RESPOND(ERR) on accept of op 3, with no storage access.
  - LOOKUP: mem_read=1 for exactly 1 cycle. mem_hit and mem_value_out are sampled at the end of that cycle.
    - GET hit → RESPOND(OK, value).
    - GET miss → RESPOND(NOT_FOUND, 0).
    - DEL hit → DELETE.
    - DEL miss → RESPOND(NOT_FOUND).
    - SET hit → DELETE (update path).
    - SET miss with entry_count==NUM_ENTRIES → RESPOND(FULL); storage untouched.
    - SET miss otherwise → WRITE.
  - DELETE: mem_delete=1 for exactly 1 cycle.
    - For DEL: entry_count−1 → RESPOND(OK).
    - For SET: count unchanged → WRITE.
  - WRITE: mem_write=1 for exactly 1 cycle.
    - Count +1 only if entered from a SET miss.
    - → RESPOND(OK).
  - RESPOND: resp_valid=1. resp_status and resp_value are held stable until resp_ready. On handshake, go to IDLE and clear resp_valid. No accept in the same cycle as the response handshake.
- Latency, from accept edge (cycle 0) to first cycle with resp_valid=1:
  - invalid op: 1
  - GET: 2
  - DEL miss: 2
  - SET full: 2
  - DEL hit: 3
  - SET miss: 3
  - SET hit: 4
- Strobe exclusivity: at most one of mem_read/mem_write/mem_delete high in any cycle. All are 0 in IDLE and RESPOND.
- entry_count never exceeds NUM_ENTRIES and never underflows below 0; guard both ends.
- resp_value=0 for every status other than GET OK.

Test Plan:
- Reset, then GET key 0x1234 → resp at cycle 2: status NOT_FOUND, value 0, entry_count 0, no mem_write/mem_delete pulses.
- SET 0x1234=0xDEADBEEF_00000001, then GET 0x1234 → SET resp at cycle 3, OK, count 1; GET resp at cycle 2, OK, value 0xDEADBEEF_00000001.
- SET 0x1234=0x5 over the existing key → single mem_delete pulse then single mem_write pulse; resp at cycle 4, OK; count stays 1; subsequent GET returns 0x5.
- Fill 16 distinct keys, then SET key 0x00FF → status FULL at cycle 2, count 16, no mem_write. DEL one key → OK, count 15. Retry SET → OK, count 16.
- req_op=3 → ERR at cycle 1, no strobes. Hold resp_ready=0 for 5 cycles → resp_valid and resp_status stay stable and req_ready stays 0. Release resp_ready → IDLE next cycle.
- Assert rst_n low during the DELETE cycle of a DEL → all strobes drop immediately, resp_valid=0, count 0. After release, req_ready=1 and GET on that key returns NOT_FOUND.

Source files
------------

// File: rtl/cache_controller.sv
// Command sequencer for the cache storage array: accepts GET/SET/DEL requests,
// drives registered read/delete/write strobes and returns a status/value response.
module cache_controller #(
  parameter int NUM_ENTRIES = 16,
  parameter int KEY_WIDTH   = 16,
  parameter int VALUE_WIDTH = 64,
  localparam int CW = $clog2(NUM_ENTRIES + 1)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [1:0]             req_op,
  input  logic [KEY_WIDTH-1:0]   req_key,
  input  logic [VALUE_WIDTH-1:0] req_value,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic [1:0]             resp_status,
  output logic [VALUE_WIDTH-1:0] resp_value,
  output logic                   mem_write,
  output logic                   mem_read,
  output logic                   mem_delete,
  output logic [KEY_WIDTH-1:0]   mem_key,
  output logic [VALUE_WIDTH-1:0] mem_value,
  input  logic [VALUE_WIDTH-1:0] mem_value_out,
  input  logic                   mem_hit,
  output logic [CW-1:0]          entry_count,
  output logic [2:0]             state_dbg
);

  // Handshakes: a transfer happens on a rising edge where valid && ready;
  // the sender holds its payload stable from raising valid until that edge.

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOOKUP  = 3'd1,
    DELETE  = 3'd2,
    WRITE   = 3'd3,
    RESPOND = 3'd4
  } state_t;

  localparam logic [1:0] OP_GET = 2'd0;
  localparam logic [1:0] OP_SET = 2'd1;
  localparam logic [1:0] OP_DEL = 2'd2;

  localparam logic [1:0] ST_OK   = 2'd0;
  localparam logic [1:0] ST_NF   = 2'd1;
  localparam logic [1:0] ST_FULL = 2'd2;
  localparam logic [1:0] ST_ERR  = 2'd3;

  localparam logic [CW-1:0] COUNT_MAX = CW'(NUM_ENTRIES);

  state_t     state;
  logic [1:0] op_q;
  logic       set_miss_q;

  assign req_ready = (state == IDLE);
  assign state_dbg = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      op_q        <= OP_GET;
      set_miss_q  <= 1'b0;
      entry_count <= '0;
      mem_read    <= 1'b0;
      mem_write   <= 1'b0;
      mem_delete  <= 1'b0;
      mem_key     <= '0;
      mem_value   <= '0;
      resp_valid  <= 1'b0;
      resp_status <= ST_OK;
      resp_value  <= '0;
    end else begin
      // Strobes are single-cycle pulses; each state re-arms the next one.
      mem_read   <= 1'b0;
      mem_write  <= 1'b0;
      mem_delete <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            op_q       <= req_op;
            mem_key    <= req_key;
            mem_value  <= req_value;
            set_miss_q <= 1'b0;
            if (req_op == ST_ERR) begin
              state       <= RESPOND;
              resp_valid  <= 1'b1;
              resp_status <= ST_ERR;
              resp_value  <= '0;
            end else begin
              state    <= LOOKUP;
              mem_read <= 1'b1;
            end
          end
        end
        LOOKUP: begin
          case (op_q)
            OP_GET: begin
              state       <= RESPOND;
              resp_valid  <= 1'b1;
              resp_status <= mem_hit ? ST_OK : ST_NF;
              resp_value  <= mem_hit ? mem_value_out : '0;
            end
            OP_DEL, OP_SET: begin
              if (mem_hit) begin
                state      <= DELETE;
                mem_delete <= 1'b1;
              end else if (op_q == OP_DEL) begin
                state       <= RESPOND;
                resp_valid  <= 1'b1;
                resp_status <= ST_NF;
                resp_value  <= '0;
              end else if (entry_count >= COUNT_MAX) begin
                state       <= RESPOND;
                resp_valid  <= 1'b1;
                resp_status <= ST_FULL;
                resp_value  <= '0;
              end else begin
                state      <= WRITE;
                mem_write  <= 1'b1;
                set_miss_q <= 1'b1;
              end
            end
            default: begin
              state       <= RESPOND;
              resp_valid  <= 1'b1;
              resp_status <= ST_ERR;
              resp_value  <= '0;
            end
          endcase
        end
        DELETE: begin
          // A SET that hit goes through delete-then-write, keeping the count.
          if (op_q == OP_SET) begin
            state     <= WRITE;
            mem_write <= 1'b1;
          end else begin
            if (entry_count != '0) entry_count <= entry_count - CW'(1);
            state       <= RESPOND;
            resp_valid  <= 1'b1;
            resp_status <= ST_OK;
            resp_value  <= '0;
          end
        end
        WRITE: begin
          if (set_miss_q && entry_count < COUNT_MAX) entry_count <= entry_count + CW'(1);
          state       <= RESPOND;
          resp_valid  <= 1'b1;
          resp_status <= ST_OK;
          resp_value  <= '0;
        end
        RESPOND: begin
          if (resp_ready) begin
            state       <= IDLE;
            resp_valid  <= 1'b0;
            resp_status <= ST_OK;
            resp_value  <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_controller.sv
// Bench for cache_controller: a slot-based storage array model answers lookups,
// and a key/value map predicts status, value, latency, strobe counts and occupancy.
module tb_cache_controller;

  localparam int N  = 16;
  localparam int KW = 16;
  localparam int VW = 64;
  localparam int CW = $clog2(N + 1);

  localparam logic [1:0] S_OK = 2'd0, S_NF = 2'd1, S_FULL = 2'd2, S_ERR = 2'd3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid, req_ready, resp_valid, resp_ready;
  logic [1:0]    req_op, resp_status;
  logic [KW-1:0] req_key, mem_key;
  logic [VW-1:0] req_value, resp_value, mem_value, mem_value_out;
  logic          mem_write, mem_read, mem_delete, mem_hit;
  logic [CW-1:0] entry_count;
  logic [2:0]    state_dbg;

  cache_controller #(.NUM_ENTRIES(N), .KEY_WIDTH(KW), .VALUE_WIDTH(VW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_key(req_key), .req_value(req_value),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_status(resp_status), .resp_value(resp_value),
    .mem_write(mem_write), .mem_read(mem_read), .mem_delete(mem_delete),
    .mem_key(mem_key), .mem_value(mem_value),
    .mem_value_out(mem_value_out), .mem_hit(mem_hit),
    .entry_count(entry_count), .state_dbg(state_dbg)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- storage array model ----------------
  logic          sv   [N];
  logic [KW-1:0] sk   [N];
  logic [VW-1:0] sval [N];
  int            hit_idx, free_idx;
  logic          free_ok;

  always_comb begin
    mem_hit = 1'b0;
    mem_value_out = '0;
    hit_idx = 0;
    free_idx = 0;
    free_ok = 1'b0;
    for (int i = 0; i < N; i++)
      if (sv[i] && sk[i] == mem_key) begin
        mem_hit = 1'b1;
        mem_value_out = sval[i];
        hit_idx = i;
      end
    for (int i = N - 1; i >= 0; i--)
      if (!sv[i]) begin
        free_ok = 1'b1;
        free_idx = i;
      end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        sv[i] <= 1'b0;
        sk[i] <= '0;
        sval[i] <= '0;
      end
    end else if (mem_write) begin
      if (mem_hit) sval[hit_idx] <= mem_value;
      else if (free_ok) begin
        sv[free_idx] <= 1'b1;
        sk[free_idx] <= mem_key;
        sval[free_idx] <= mem_value;
      end
    end else if (mem_delete && mem_hit) begin
      sv[hit_idx] <= 1'b0;
    end
  end

  // ---------------- strobe monitor ----------------
  int rd_cnt = 0, wr_cnt = 0, del_cnt = 0, excl_bad = 0;

  always @(negedge clk) begin
    if (mem_read)   rd_cnt  <= rd_cnt + 1;
    if (mem_write)  wr_cnt  <= wr_cnt + 1;
    if (mem_delete) del_cnt <= del_cnt + 1;
    if ((int'(mem_read) + int'(mem_write) + int'(mem_delete)) > 1) excl_bad <= excl_bad + 1;
    else if ((req_ready || resp_valid) && (mem_read || mem_write || mem_delete))
      excl_bad <= excl_bad + 1;
  end

  // ---------------- scoreboard ----------------
  logic [VW-1:0] ref_map [logic [KW-1:0]];
  int n_vec = 0, n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- driver ----------------
  task automatic do_req(input logic [1:0] op, input logic [KW-1:0] key,
                        input logic [VW-1:0] val, input int hold);
    logic [1:0]    e_st, st0;
    logic [VW-1:0] e_val, v0;
    int e_lat, e_r, e_w, e_d, n, r0, w0, d0;
    bit hit;
    hit = ref_map.exists(key);
    e_r = (op != 2'd3) ? 1 : 0;
    e_w = 0; e_d = 0; e_val = '0; e_st = S_OK;
    case (op)
      2'd0: begin
        e_lat = 2;
        if (hit) e_val = ref_map[key]; else e_st = S_NF;
      end
      2'd1: begin
        if (hit) begin e_lat = 4; e_d = 1; e_w = 1; ref_map[key] = val; end
        else if (ref_map.num() >= N) begin e_lat = 2; e_st = S_FULL; end
        else begin e_lat = 3; e_w = 1; ref_map[key] = val; end
      end
      2'd2: begin
        if (hit) begin e_lat = 3; e_d = 1; ref_map.delete(key); end
        else begin e_lat = 2; e_st = S_NF; end
      end
      default: begin e_lat = 1; e_st = S_ERR; end
    endcase

    @(negedge clk);
    n = 0;
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    chk("req_ready_before", req_ready, 1);
    r0 = rd_cnt; w0 = wr_cnt; d0 = del_cnt;
    req_valid = 1'b1; req_op = op; req_key = key; req_value = val;
    @(posedge clk);
    #1 req_valid = 1'b0;
    req_op = 2'($urandom_range(0, 3));
    req_key = KW'($urandom);
    req_value = {$urandom, $urandom};

    n = 0;
    do begin @(negedge clk); n++; end while (!resp_valid && n < 20);
    chk("latency", n, e_lat);
    chk("status", resp_status, e_st);
    chk("value", resp_value, e_val);
    st0 = resp_status; v0 = resp_value;
    repeat (hold) begin
      @(negedge clk);
      chk("hold_valid", resp_valid, 1);
      chk("hold_status", resp_status, st0);
      chk("hold_value", resp_value, v0);
      chk("hold_req_ready", req_ready, 0);
    end
    resp_ready = 1'b1;
    @(posedge clk);
    #1 resp_ready = 1'b0;
    @(negedge clk);
    chk("resp_dropped", resp_valid, 0);
    chk("idle_after_resp", req_ready, 1);
    chk("entry_count", entry_count, ref_map.num());
    chk("read_pulses", rd_cnt - r0, e_r);
    chk("write_pulses", wr_cnt - w0, e_w);
    chk("delete_pulses", del_cnt - d0, e_d);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0;
    req_valid = 1'b0; req_op = '0; req_key = '0; req_value = '0;
    resp_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_count", entry_count, 0);
    chk("rst_strobes", {mem_read, mem_write, mem_delete}, 0);
    chk("rst_mem_key", mem_key, 0);
    chk("rst_mem_value", mem_value, 0);
    chk("rst_resp", {resp_valid, resp_status}, 0);
    chk("rst_resp_value", resp_value, 0);
    rst_n = 1'b1;

    do_req(2'd0, 16'h1234, '0, 0);
    do_req(2'd1, 16'h1234, 64'hDEADBEEF_00000001, 1);
    do_req(2'd0, 16'h1234, '0, 0);
    do_req(2'd1, 16'h1234, 64'h5, 0);
    do_req(2'd0, 16'h1234, '0, 2);

    for (int i = 0; i < N - 1; i++) do_req(2'd1, 16'h2000 + KW'(i), {$urandom, $urandom}, 0);
    do_req(2'd1, 16'h00FF, 64'h77, 0);
    do_req(2'd2, 16'h1234, '0, 0);
    do_req(2'd1, 16'h00FF, 64'h77, 0);
    do_req(2'd3, 16'hABCD, 64'h1, 5);

    // Reset during the delete cycle of a DEL.
    @(negedge clk);
    req_valid = 1'b1; req_op = 2'd2; req_key = 16'h00FF;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    chk("mid_lookup_read", mem_read, 1);
    @(negedge clk);
    chk("mid_delete_strobe", mem_delete, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_strobes", {mem_read, mem_write, mem_delete}, 0);
    chk("mid_rst_resp_valid", resp_valid, 0);
    chk("mid_rst_count", entry_count, 0);
    ref_map.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", req_ready, 1);
    do_req(2'd0, 16'h00FF, '0, 0);

    for (int i = 0; i < 300; i++) begin
      int sel;
      logic [1:0] op;
      sel = $urandom_range(0, 9);
      op = (sel < 3) ? 2'd0 : (sel < 6) ? 2'd1 : (sel < 9) ? 2'd2 : 2'd3;
      do_req(op, 16'h0100 + KW'($urandom_range(0, 19)), {$urandom, $urandom},
             $urandom_range(0, 2));
    end

    @(negedge clk);
    chk("strobe_exclusive", excl_bad, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
